// File: rtl/spi_slave_axis_8.sv
// SPI mode-0 slave bridged to an 8-bit AXI stream, oversampled in the clk domain.
// Received bytes sit in a one-byte hold until the next byte or CS release decides tlast.
`timescale 1ns/1ps
module spi_slave_axis_8 #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] output_axis_tdata,
  output logic       output_axis_tvalid,
  input  logic       output_axis_tready,
  output logic       output_axis_tlast,
  input  logic [7:0] input_axis_tdata,
  input  logic       input_axis_tvalid,
  output logic       input_axis_tready,
  input  logic       input_axis_tlast,
  output logic       busy,
  output logic       overflow
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

  logic [SS-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic          r_sck_d, r_cs_d;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic [7:0] r_hold_data;
  logic       r_hold_valid, r_hold_last;
  logic [7:0] r_out_data;
  logic       r_out_valid, r_out_last;
  logic       r_ovf;

  logic       w_sck, w_cs, w_mosi;
  logic       w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic       w_rx_edge, w_byte_done, w_load;
  logic [7:0] w_rx_byte;
  logic       w_out_free, w_flush_move, w_push_move, w_byte_to_hold, w_drop;
  logic       w_hold_valid_next;
  logic       w_unused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SS-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SS-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SS-2:0], spi_mosi};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
    end
  end

  assign w_sck  = r_sck_sync[SS-1];
  assign w_cs   = r_cs_sync[SS-1];
  assign w_mosi = r_mosi_sync[SS-1];

  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = ~w_cs & r_cs_d;
  assign w_cs_rise  = w_cs & ~r_cs_d;

  // SCK edges count only while the synchronised CS is low; frame start wins over a coincident edge
  assign w_rx_edge   = w_sck_rise & ~w_cs & ~w_cs_fall;
  assign w_byte_done = w_rx_edge & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx, w_mosi};
  assign w_load      = w_cs_fall | w_byte_done;

  // A finished frame's last byte owns the hold until it reaches the output register
  assign w_out_free        = ~r_out_valid | output_axis_tready;
  assign w_flush_move      = r_hold_valid & r_hold_last & w_out_free;
  assign w_push_move       = w_byte_done & ~r_hold_last & r_hold_valid & w_out_free;
  assign w_byte_to_hold    = w_byte_done & ~r_hold_last & (~r_hold_valid | w_out_free);
  assign w_drop            = w_byte_done & ~w_byte_to_hold;
  assign w_hold_valid_next = w_byte_to_hold | (r_hold_valid & ~w_flush_move);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_rx         <= 7'd0;
      r_tx         <= 8'd0;
      r_hold_data  <= 8'd0;
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
      r_out_data   <= 8'd0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_ovf <= w_drop;

      if (w_flush_move) begin
        r_out_data  <= r_hold_data;
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b1;
      end else if (w_push_move) begin
        r_out_data  <= r_hold_data;
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b0;
      end else if (output_axis_tready) begin
        r_out_valid <= 1'b0;
      end

      if (w_byte_to_hold) r_hold_data <= w_rx_byte;
      r_hold_valid <= w_hold_valid_next;
      r_hold_last  <= w_hold_valid_next & (w_cs_rise | (r_hold_last & ~w_flush_move));

      if (w_cs_fall) begin
        r_bit_cnt <= 3'd0;
        r_rx      <= 7'd0;
      end else if (w_rx_edge) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= w_rx_byte[6:0];
      end

      // The falling edge right after a reload (bit_cnt == 0) must not shift
      if (w_load)
        r_tx <= input_axis_tvalid ? input_axis_tdata : IDLE_BYTE;
      else if (w_sck_fall & ~w_cs & (r_bit_cnt != 3'd0))
        r_tx <= {r_tx[6:0], 1'b0};

      if (w_cs_fall)
        r_state <= S_ACTIVE;
      else if (w_cs_rise)
        r_state <= w_hold_valid_next ? S_FLUSH : S_IDLE;
      else if ((r_state == S_FLUSH) && w_flush_move)
        r_state <= S_IDLE;
    end
  end

  assign input_axis_tready  = w_load & input_axis_tvalid;
  assign spi_miso           = (r_state == S_ACTIVE) & r_tx[7];
  assign output_axis_tdata  = r_out_data;
  assign output_axis_tvalid = r_out_valid;
  assign output_axis_tlast  = r_out_last;
  assign overflow           = r_ovf;
  assign busy               = (r_state != S_IDLE) | r_out_valid;
  assign w_unused           = input_axis_tlast;

endmodule
